// File: rtl/agc_loop_ctrl.sv
// agc_loop_ctrl: supervisory loop controller for the agc datapath.
// Measures the peak |y_in| over fixed windows of valid samples and ramps the
// reference toward ref_target. It sequences the loop from fast-coefficient
// acquisition to slow-coefficient tracking once the level holds within tolerance.
module agc_loop_ctrl #(
    parameter int unsigned WIN_LOG2  = 8,
    parameter logic [7:0]  A_FAST    = 8'h3F,
    parameter logic [7:0]  A_SLOW    = 8'h0F,
    parameter logic [15:0] LOCK_TOL  = 16'h0400,
    parameter int unsigned LOCK_CNT  = 4,
    parameter logic [15:0] RAMP_STEP = 16'h0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sample_vld,
    input  logic [15:0] y_in,
    input  logic [15:0] ref_target,
    output logic [15:0] reference,
    output logic [7:0]  a_coef,
    output logic        locked,
    output logic [1:0]  state,
    output logic [15:0] peak,
    output logic        peak_vld
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        TRACK   = 2'b10
    } state_t;

    localparam logic [7:0]  LOCK_CNT_W = 8'(LOCK_CNT);
    localparam logic [16:0] TOL_ACQ    = {1'b0, LOCK_TOL};
    localparam logic [16:0] TOL_TRK    = {LOCK_TOL, 1'b0};

    state_t                state_q, state_d;
    logic [15:0]           reference_q, reference_d;
    logic [7:0]            a_coef_q, a_coef_d;
    logic                  locked_q, locked_d;
    logic [15:0]           peak_q, peak_d;
    logic                  peak_vld_q, peak_vld_d;
    logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
    logic [15:0]           run_max_q, run_max_d;
    logic [7:0]            good_q, good_d;

    logic [15:0] mag;
    logic [15:0] run_new;
    logic [15:0] ramp_next;
    logic [16:0] err;
    logic        win_end;

    // Saturating magnitude, windowed running max, err against the current reference and the next ramp value
    always_comb begin
        if (y_in == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (y_in[15]) begin
            mag = ~y_in + 16'd1;
        end else begin
            mag = y_in;
        end

        run_new = (mag > run_max_q) ? mag : run_max_q;
        win_end = sample_vld && (win_cnt_q == '1);

        if (run_new >= reference_q) begin
            err = {1'b0, run_new} - {1'b0, reference_q};
        end else begin
            err = {1'b0, reference_q} - {1'b0, run_new};
        end

        if (ref_target > reference_q) begin
            ramp_next = ((ref_target - reference_q) <= RAMP_STEP) ? ref_target
                                                                  : reference_q + RAMP_STEP;
        end else if (ref_target < reference_q) begin
            ramp_next = ((reference_q - ref_target) <= RAMP_STEP) ? ref_target
                                                                  : reference_q - RAMP_STEP;
        end else begin
            ramp_next = reference_q;
        end
    end

    // Next-state logic: sequencing, window bookkeeping and ramp; en=0 overrides everything
    always_comb begin
        state_d     = state_q;
        reference_d = reference_q;
        peak_d      = peak_q;
        peak_vld_d  = 1'b0;
        win_cnt_d   = win_cnt_q;
        run_max_d   = run_max_q;
        good_d      = good_q;

        if (!en) begin
            state_d   = IDLE;
            win_cnt_d = '0;
            run_max_d = '0;
            good_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = ACQUIRE;
                    win_cnt_d = '0;
                    run_max_d = '0;
                    good_d    = '0;
                end
                ACQUIRE, TRACK: begin
                    if (sample_vld) begin
                        reference_d = ramp_next;
                        if (win_end) begin
                            peak_d     = run_new;
                            peak_vld_d = 1'b1;
                            win_cnt_d  = '0;
                            run_max_d  = '0;
                        end else begin
                            win_cnt_d  = win_cnt_q + WIN_LOG2'(1);
                            run_max_d  = run_new;
                        end
                    end

                    if (state_q == ACQUIRE) begin
                        if (win_end) begin
                            if (err <= TOL_ACQ && reference_q == ref_target) begin
                                if (good_q + 8'd1 == LOCK_CNT_W) begin
                                    state_d = TRACK;
                                    good_d  = '0;
                                end else begin
                                    good_d  = good_q + 8'd1;
                                end
                            end else begin
                                good_d = '0;
                            end
                        end
                    end else begin
                        // Level loss and target change both collapse into one ACQUIRE transition
                        if ((win_end && err > TOL_TRK) || ref_target != reference_q) begin
                            state_d = ACQUIRE;
                            good_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                    run_max_d = '0;
                    good_d    = '0;
                end
            endcase
        end

        locked_d = (state_d == TRACK);
        a_coef_d = (state_d == TRACK) ? A_SLOW : A_FAST;
    end

    // State and registered outputs with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            reference_q <= '0;
            a_coef_q    <= A_FAST;
            locked_q    <= 1'b0;
            peak_q      <= '0;
            peak_vld_q  <= 1'b0;
            win_cnt_q   <= '0;
            run_max_q   <= '0;
            good_q      <= '0;
        end else begin
            state_q     <= state_d;
            reference_q <= reference_d;
            a_coef_q    <= a_coef_d;
            locked_q    <= locked_d;
            peak_q      <= peak_d;
            peak_vld_q  <= peak_vld_d;
            win_cnt_q   <= win_cnt_d;
            run_max_q   <= run_max_d;
            good_q      <= good_d;
        end
    end

    assign reference = reference_q;
    assign a_coef    = a_coef_q;
    assign locked    = locked_q;
    assign state     = state_q;
    assign peak      = peak_q;
    assign peak_vld  = peak_vld_q;

endmodule
